// File: rtl/escalonador_pkg.sv
// Shared encodings and default sizing for the round-robin process scheduler.
package escalonador_pkg;

    localparam int NUM_PROC_DEF = 4;
    localparam int PID_W_DEF    = 2;
    localparam int PC_W_DEF     = 32;
    localparam int QUANTUM_DEF  = 16;
    localparam int CONT_W       = 8;

    typedef enum logic [1:0] {
        LIVRE     = 2'b00,
        PRONTO    = 2'b01,
        BLOQUEADO = 2'b10
    } estado_slot_t;

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        EXECUTANDO = 2'b01,
        SELECIONAR = 2'b10,
        CARREGAR   = 2'b11
    } estado_fsm_t;

endpackage

// File: rtl/seletor_round_robin.sv
// Rotating priority search: first ready slot after inicio_i, wrapping so inicio_i is checked last.
// Purely combinational; no handshake.
module seletor_round_robin
    import escalonador_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int PID_W    = PID_W_DEF
) (
    input  logic [NUM_PROC-1:0] prontos_i,
    input  logic [PID_W-1:0]    inicio_i,
    output logic                achou_o,
    output logic [PID_W-1:0]    sel_o
);

    int idx;

    // Walk from the farthest candidate back to the nearest so the nearest hit wins.
    always_comb begin
        achou_o = 1'b0;
        sel_o   = '0;
        idx     = 0;
        for (int k = NUM_PROC; k >= 1; k--) begin
            idx = (int'(inicio_i) + k) % NUM_PROC;
            if (prontos_i[idx[PID_W-1:0]]) begin
                achou_o = 1'b1;
                sel_o   = idx[PID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler: quantum/IO/exit events save the PC and dispatch the next ready slot.
// Event at T -> select at T+1 -> troca_contexto pulse at T+2 -> CPU runs at T+3; cpu_parada stalls the CPU meanwhile.
module escalonador_round_robin
    import escalonador_pkg::*;
#(
    parameter int NUM_PROC = NUM_PROC_DEF,
    parameter int PID_W    = PID_W_DEF,
    parameter int PC_W     = PC_W_DEF,
    parameter int QUANTUM  = QUANTUM_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ativa_processo,
    input  logic [PID_W-1:0]    id_novo,
    input  logic [PC_W-1:0]     pc_inicial,
    input  logic                instr_exec,
    input  logic [PC_W-1:0]     pc_atual,
    input  logic                pedido_io,
    input  logic [NUM_PROC-1:0] io_concluido,
    input  logic                fim_processo,
    output logic                troca_contexto,
    output logic [PC_W-1:0]     pc_carregar,
    output logic [PID_W-1:0]    processo_atual,
    output logic                processo_valido,
    output logic                cpu_parada
);

    localparam logic [CONT_W-1:0] CONT_ULTIMO = CONT_W'(QUANTUM - 1);

    estado_slot_t       estado_q   [NUM_PROC];
    estado_slot_t       estado_d   [NUM_PROC];
    logic [PC_W-1:0]    pc_salvo_q [NUM_PROC];
    logic [PC_W-1:0]    pc_salvo_d [NUM_PROC];
    estado_fsm_t        fsm_q, fsm_d;
    logic [CONT_W-1:0]  cont_q, cont_d;
    logic [PC_W-1:0]    pc_carregar_q, pc_carregar_d;
    logic [PID_W-1:0]   proc_atual_q, proc_atual_d;

    logic [NUM_PROC-1:0] prontos;
    logic                achou;
    logic [PID_W-1:0]    sel;

    // Readiness is taken from registered state, so same-cycle activations are seen one cycle later.
    always_comb begin
        prontos = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            prontos[i] = (estado_q[i] == PRONTO);
        end
    end

    seletor_round_robin #(
        .NUM_PROC (NUM_PROC),
        .PID_W    (PID_W)
    ) u_seletor (
        .prontos_i (prontos),
        .inicio_i  (proc_atual_q),
        .achou_o   (achou),
        .sel_o     (sel)
    );

    always_comb begin
        fsm_d         = fsm_q;
        cont_d        = cont_q;
        pc_carregar_d = pc_carregar_q;
        proc_atual_d  = proc_atual_q;
        estado_d      = estado_q;
        pc_salvo_d    = pc_salvo_q;

        for (int i = 0; i < NUM_PROC; i++) begin
            if (io_concluido[i] && estado_q[i] == BLOQUEADO) begin
                estado_d[i] = PRONTO;
            end
            if (ativa_processo && id_novo == PID_W'(i) && estado_q[i] == LIVRE) begin
                estado_d[i]   = PRONTO;
                pc_salvo_d[i] = pc_inicial;
            end
        end

        case (fsm_q)
            OCIOSO: begin
                if (|prontos) fsm_d = SELECIONAR;
            end
            EXECUTANDO: begin
                if (fim_processo) begin
                    estado_d[proc_atual_q] = LIVRE;
                    fsm_d                  = SELECIONAR;
                end else if (pedido_io) begin
                    // Running slot is PRONTO, so a coincident io_concluido above cannot undo this block.
                    estado_d[proc_atual_q]   = BLOQUEADO;
                    pc_salvo_d[proc_atual_q] = pc_atual;
                    fsm_d                    = SELECIONAR;
                end else if (instr_exec) begin
                    if (cont_q == CONT_ULTIMO) begin
                        pc_salvo_d[proc_atual_q] = pc_atual;
                        fsm_d                    = SELECIONAR;
                    end else begin
                        cont_d = cont_q + 1'b1;
                    end
                end
            end
            SELECIONAR: begin
                if (achou) begin
                    proc_atual_d  = sel;
                    pc_carregar_d = pc_salvo_q[sel];
                    fsm_d         = CARREGAR;
                end else begin
                    fsm_d = OCIOSO;
                end
            end
            CARREGAR: begin
                cont_d = '0;
                fsm_d  = EXECUTANDO;
            end
            default: fsm_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q         <= OCIOSO;
            cont_q        <= '0;
            pc_carregar_q <= '0;
            proc_atual_q  <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                estado_q[i]   <= LIVRE;
                pc_salvo_q[i] <= '0;
            end
        end else begin
            fsm_q         <= fsm_d;
            cont_q        <= cont_d;
            pc_carregar_q <= pc_carregar_d;
            proc_atual_q  <= proc_atual_d;
            for (int i = 0; i < NUM_PROC; i++) begin
                estado_q[i]   <= estado_d[i];
                pc_salvo_q[i] <= pc_salvo_d[i];
            end
        end
    end

    // Outputs decode the registered FSM state, so reset clears the pulse at once.
    assign troca_contexto  = (fsm_q == CARREGAR);
    assign processo_valido = (fsm_q == EXECUTANDO);
    assign cpu_parada      = (fsm_q != EXECUTANDO);
    assign pc_carregar     = pc_carregar_q;
    assign processo_atual  = proc_atual_q;

endmodule

// File: tb/tb_escalonador_round_robin.sv
// Directed bench for the round-robin scheduler with a 4-instruction quantum.
module tb_escalonador_round_robin;

    logic        clock = 1'b0;
    logic        reset;
    logic        ativa_processo;
    logic [1:0]  id_novo;
    logic [31:0] pc_inicial;
    logic        instr_exec;
    logic [31:0] pc_atual;
    logic        pedido_io;
    logic [3:0]  io_concluido;
    logic        fim_processo;
    logic        troca_contexto;
    logic [31:0] pc_carregar;
    logic [1:0]  processo_atual;
    logic        processo_valido;
    logic        cpu_parada;

    int total = 0;
    int bad   = 0;

    escalonador_round_robin #(
        .NUM_PROC (4),
        .PID_W    (2),
        .PC_W     (32),
        .QUANTUM  (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ativa_processo  (ativa_processo),
        .id_novo         (id_novo),
        .pc_inicial      (pc_inicial),
        .instr_exec      (instr_exec),
        .pc_atual        (pc_atual),
        .pedido_io       (pedido_io),
        .io_concluido    (io_concluido),
        .fim_processo    (fim_processo),
        .troca_contexto  (troca_contexto),
        .pc_carregar     (pc_carregar),
        .processo_atual  (processo_atual),
        .processo_valido (processo_valido),
        .cpu_parada      (cpu_parada)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input logic [31:0] pc);
        instr_exec = 1'b1;
        pc_atual   = pc;
        tick();
        instr_exec = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input logic [31:0] pc, input logic [31:0] pid);
        chk({tag, "_troca"}, 32'(troca_contexto), 1);
        chk({tag, "_pc"}, pc_carregar, pc);
        chk({tag, "_pid"}, 32'(processo_atual), pid);
        chk({tag, "_parada"}, 32'(cpu_parada), 1);
    endtask

    initial begin
        #20000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; ativa_processo = 1'b0; id_novo = '0; pc_inicial = '0;
        instr_exec = 1'b0; pc_atual = '0; pedido_io = 1'b0; io_concluido = '0; fim_processo = 1'b0;
        #3;
        chk("rst_troca", 32'(troca_contexto), 0);
        chk("rst_pc", pc_carregar, 0);
        chk("rst_pid", 32'(processo_atual), 0);
        chk("rst_valido", 32'(processo_valido), 0);
        chk("rst_parada", 32'(cpu_parada), 1);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("idle_parada", 32'(cpu_parada), 1);

        // Dispatch; pid2 activated during SELECIONAR is not seen yet
        ativa_processo = 1'b1; id_novo = 2'd0; pc_inicial = 32'd100;
        tick();
        ativa_processo = 1'b0;
        tick();
        chk("sel_troca", 32'(troca_contexto), 0);
        ativa_processo = 1'b1; id_novo = 2'd2; pc_inicial = 32'd200;
        tick();
        ativa_processo = 1'b0;
        chk_pulse("disp0", 100, 0);
        tick();
        chk("exec_troca", 32'(troca_contexto), 0);
        chk("exec_parada", 32'(cpu_parada), 0);
        chk("exec_valido", 32'(processo_valido), 1);

        // Preemption
        for (int i = 1; i <= 4; i++) run_instr(32'(100 + i));
        chk("q_sel_parada", 32'(cpu_parada), 1);
        chk("q_sel_troca", 32'(troca_contexto), 0);
        tick();
        chk_pulse("pre2", 200, 2);
        tick();
        for (int i = 1; i <= 4; i++) run_instr(32'(200 + i));
        tick();
        chk_pulse("pre0", 104, 0);
        tick();
        for (int i = 5; i <= 8; i++) run_instr(32'(100 + i));
        tick();
        chk_pulse("pre2b", 204, 2);
        tick();

        // IO block with a coincident completion for the running slot
        pedido_io = 1'b1; pc_atual = 32'd205; io_concluido = 4'b0100;
        tick();
        pedido_io = 1'b0; io_concluido = '0;
        tick();
        chk_pulse("io_disp0", 108, 0);
        tick();
        io_concluido = 4'b0010;
        tick();
        io_concluido = 4'b0100;
        tick();
        io_concluido = '0;
        for (int i = 9; i <= 12; i++) run_instr(32'(100 + i));
        tick();
        chk_pulse("io_back2", 205, 2);
        tick();

        // Exit coincident with quantum expiry
        for (int i = 6; i <= 8; i++) run_instr(32'(200 + i));
        instr_exec = 1'b1; fim_processo = 1'b1; pc_atual = 32'd999;
        tick();
        instr_exec = 1'b0; fim_processo = 1'b0;
        tick();
        chk_pulse("fimq_disp0", 112, 0);
        tick();

        // Single ready process re-dispatched with its own PC
        for (int i = 13; i <= 16; i++) run_instr(32'(100 + i));
        tick();
        chk_pulse("solo", 116, 0);
        tick();

        // Termination of the last process
        fim_processo = 1'b1;
        tick();
        fim_processo = 1'b0;
        tick();
        chk("term_troca", 32'(troca_contexto), 0);
        chk("term_valido", 32'(processo_valido), 0);
        chk("term_parada", 32'(cpu_parada), 1);
        tick();
        chk("term_idle_troca", 32'(troca_contexto), 0);

        ativa_processo = 1'b1; id_novo = 2'd3; pc_inicial = 32'd300;
        tick();
        ativa_processo = 1'b0;
        tick();
        chk("wake_early", 32'(troca_contexto), 0);
        tick();
        chk_pulse("wake3", 300, 3);
        tick();

        // Activations on already-PRONTO slots are ignored
        ativa_processo = 1'b1; id_novo = 2'd1; pc_inicial = 32'd400;
        tick();
        pc_inicial = 32'd999;
        tick();
        id_novo = 2'd3; pc_inicial = 32'd888;
        tick();
        ativa_processo = 1'b0;
        pedido_io = 1'b1; pc_atual = 32'd301;
        tick();
        pedido_io = 1'b0;
        tick();
        chk_pulse("dup1", 400, 1);
        tick();
        io_concluido = 4'b1000;
        tick();
        io_concluido = '0;
        for (int i = 1; i <= 4; i++) run_instr(32'(400 + i));
        tick();
        chk_pulse("dup3", 301, 3);

        // Reset in the middle of the pulse
        reset = 1'b0;
        #1;
        chk("mid_rst_troca", 32'(troca_contexto), 0);
        chk("mid_rst_pc", pc_carregar, 0);
        chk("mid_rst_parada", 32'(cpu_parada), 1);
        chk("mid_rst_pid", 32'(processo_atual), 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valido", 32'(processo_valido), 0);
            chk("post_rst_troca", 32'(troca_contexto), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/escalonador_round_robin.md
Name: escalonador_round_robin

Overview:
- Hardware round-robin process scheduler for the multiprogrammed CPU.
- Holds a small process table (slot state and saved PC) and counts retired instructions against a quantum.
- On quantum expiry, an IO request or process termination, it saves the running PC, selects the next ready process and issues a one-cycle context-switch pulse carrying the PC the CPU must load.
- Sits beside the CPU PC-update logic; its outputs feed the CPU's context-switch mux and stall input.

Parameters:
- NUM_PROC, 4, number of process slots.
- PID_W, 2, process id width, clog2(NUM_PROC).
- PC_W, 32, PC width.
- QUANTUM, 16, instructions per time slice; legal range 2..255.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; resets when 0.
- ativa_processo  in  1  load a new process into slot id_novo.
- id_novo  in  PID_W  slot to load.
- pc_inicial  in  PC_W  entry PC of the new process.
- instr_exec  in  1  one instruction of the running process retired this cycle.
- pc_atual  in  PC_W  PC of the next instruction of the running process; valid with instr_exec, pedido_io and fim_processo.
- pedido_io  in  1  running process issued IO and blocks.
- io_concluido  in  NUM_PROC  per-slot IO completion pulse.
- fim_processo  in  1  running process terminated.
- troca_contexto  out  1  one-cycle pulse: CPU loads pc_carregar.
- pc_carregar  out  PC_W  PC to load, held until the next switch.
- processo_atual  out  PID_W  id of the running or last selected process.
- processo_valido  out  1  a process is running.
- cpu_parada  out  1  CPU must stall (no fetch/retire).

Behaviour:
- Slot states: LIVRE, PRONTO, BLOQUEADO. The running slot stays PRONTO. Each slot holds pc_salvo[PC_W].
- Reset values: all slots LIVRE; pc_salvo=0; FSM=OCIOSO; quantum counter=0; troca_contexto=0; pc_carregar=0; processo_atual=0; processo_valido=0; cpu_parada=1.
- ativa_processo: only accepted when slot id_novo is LIVRE. It sets the slot to PRONTO and pc_salvo=pc_inicial. It is accepted in any FSM state and ignored otherwise.
- io_concluido[i]: moves slot i BLOQUEADO->PRONTO. Ignored for slots in any other state.
- FSM OCIOSO: cpu_parada=1, processo_valido=0. If any slot is PRONTO, go to SELECIONAR next cycle.
- FSM EXECUTANDO: cpu_parada=0, processo_valido=1. Event priority is fim_processo > pedido_io > quantum expiry.
  - fim_processo: slot becomes LIVRE, no PC save, go to SELECIONAR.
  - pedido_io: pc_salvo=pc_atual, slot becomes BLOQUEADO, go to SELECIONAR.
  - instr_exec with counter==QUANTUM-1: pc_salvo=pc_atual, slot stays PRONTO, go to SELECIONAR.
  - Otherwise, instr_exec increments the counter.
- FSM SELECIONAR: cpu_parada=1. Search slots processo_atual+1 .. processo_atual+NUM_PROC mod NUM_PROC, so the current slot is checked last. The first PRONTO slot goes to CARREGAR; if none is found, go to OCIOSO.
  - A slot activated or unblocked in this same cycle is not seen until the next cycle.
- FSM CARREGAR: cpu_parada=1. Pulse troca_contexto=1; set pc_carregar=pc_salvo[sel] and processo_atual=sel; clear the counter; go to EXECUTANDO.
  - A single ready process is re-dispatched with its own PC.
- Latency: event at cycle T, SELECIONAR at T+1, troca_contexto pulse at T+2, EXECUTANDO (CPU runs) at T+3. From OCIOSO, the pulse comes 2 cycles after a slot becomes PRONTO.
- Ignored inputs: instr_exec, pedido_io and fim_processo are ignored outside EXECUTANDO.
- Same-cycle conflicts:
  - pedido_io with io_concluido for the running slot: the block wins, because the slot was not BLOQUEADO yet.
  - ativa_processo while its slot is freed in the same cycle: ignored.
- Counter width is 8 bits; it is never compared past QUANTUM-1.
- Reset asserted in any state returns everything to reset values immediately, including mid-pulse.

Decomposition:
- Package escalonador_pkg: slot state encoding (LIVRE=2'b00, PRONTO=2'b01, BLOQUEADO=2'b10), FSM state encoding (OCIOSO, EXECUTANDO, SELECIONAR, CARREGAR), and default parameter constants.
- One sub-module, seletor_round_robin: combinational rotating priority search. Inputs are the ready vector and the start index; outputs are found and sel.

Test Plan:
- Dispatch: release reset, ativa pid0 pc=100, then pid2 pc=200 -> troca_contexto pulse with pc_carregar=100, processo_atual=0, cpu_parada low the following cycle.
- Preemption: QUANTUM=4, 4x instr_exec with last pc_atual=104 -> pulse with pc_carregar=200, pid2. After 4 more (pc_atual=204) -> pc_carregar=104, pid0.
- IO block: pid2 running, pedido_io with pc_atual=205 -> pid0 dispatched. io_concluido[2] -> next preemption loads pc_carregar=205, pid2. io_concluido[1] on a LIVRE slot changes nothing.
- Termination: only process fim_processo -> no pulse, OCIOSO, processo_valido=0, cpu_parada=1. Later ativa pid3 pc=300 -> pulse 2 cycles after acceptance, pc_carregar=300.
- Conflicts: fim_processo coincident with quantum expiry -> slot LIVRE, pc_salvo unchanged. ativa_processo on a PRONTO slot -> pc_salvo unchanged.
- Reset mid-operation: assert reset=0 during CARREGAR -> troca_contexto=0, pc_carregar=0, cpu_parada=1 immediately; all slots LIVRE after release.
